// File: rtl/reduce_nx1_seq.sv
// reduce_nx1_seq: multi-cycle bit-reduction engine (OR / AND / XOR / NOR).
// A WIDTH-bit operand is reduced to one bit, CHUNK bits per clock, under a
// START / BUSY / DONE handshake. Synchronous active-high reset.
// Optional build macro REDUCE_EARLY_EXIT_EN: stop consuming chunks as soon as
// the result is decided (OR/NOR on a chunk containing a 1, AND on a chunk
// containing a 0). RESULT is the same in both builds; only CYC_CNT and latency
// differ.
module reduce_nx1_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  localparam int N  = WIDTH / CHUNK,
  localparam int CW = $clog2(N + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] OPERAND,
  output logic             BUSY,
  output logic             DONE,
  output logic             RESULT,
  output logic [CW-1:0]    CYC_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    M_OR  = 2'b00,
    M_AND = 2'b01,
    M_XOR = 2'b10,
    M_NOR = 2'b11
  } mode_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t             state;
  mode_t              mode_q;
  logic [WIDTH-1:0]   opr_q;
  logic [CW-1:0]      idx_q;
  logic               acc_q;
  logic               acc_nxt;
  logic               stop;
  logic [CHUNK-1:0]   chunk;

  // The latched operand is shifted down one chunk per BUSY cycle, so the
  // current chunk is always the low CHUNK bits (LSB chunk first).
  assign chunk = opr_q[CHUNK-1:0];

  // Fold the current chunk into the accumulator according to the latched mode.
  always_comb begin
    acc_nxt = acc_q;
    case (mode_q)
      M_OR, M_NOR: acc_nxt = acc_q | (|chunk);
      M_AND:       acc_nxt = acc_q & (&chunk);
      M_XOR:       acc_nxt = acc_q ^ (^chunk);
      default:     acc_nxt = acc_q;
    endcase
  end

  // Decide whether the chunk being consumed this cycle is the final one.
  always_comb begin
    stop = (idx_q == LAST_IDX);
`ifdef REDUCE_EARLY_EXIT_EN
    case (mode_q)
      M_OR, M_NOR: if (|chunk)    stop = 1'b1;
      M_AND:       if (!(&chunk)) stop = 1'b1;
      default:     ;
    endcase
`endif
  end

  // Control FSM with registered handshake outputs, result and cycle count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      mode_q  <= M_OR;
      opr_q   <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= 1'b0;
      CYC_CNT <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            state  <= S_BUSY;
            BUSY   <= 1'b1;
            mode_q <= mode_t'(MODE);
            opr_q  <= OPERAND;
            idx_q  <= '0;
            acc_q  <= (mode_t'(MODE) == M_AND);
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        S_BUSY: begin
          acc_q <= acc_nxt;
          idx_q <= idx_q + 1'b1;
          opr_q <= opr_q >> CHUNK;
          if (stop) begin
            state   <= S_DONE;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            RESULT  <= acc_nxt ^ (mode_q == M_NOR);
            CYC_CNT <= idx_q + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
